cache_arbiter: RTL and testbench

- Shares the single system-memory cache-line port between the L1 instruction cache (read-only) and the L1 data cache (read/write).
- Accepts one cache-line request at a time and forwards it to system memory, then returns the acknowledge to the requester that issued it.
- Sits between the L1IC_ARB/L1DC_ARB slave sides and the SysMem master side.
- All transfers use valid/rdy; a transfer occurs on any cycle where both valid and rdy are high.

---
 rtl/cache_arbiter_pkg.sv | 38 +++
 rtl/arb_rr2.sv | 26 ++
 rtl/cache_arbiter.sv | 116 +++++++++++
 tb/tb_cache_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1 IC/DC to system-memory cache-line arbiter.
// Line geometry, DC request bundle, FSM state codes, owner codes.
package cache_arbiter_pkg;

  localparam int PC_SZ  = 32;
  localparam int CL_SZ  = 4;
  localparam int CL_LEN = 16;

  localparam int ARB_ADDR_W = PC_SZ - CL_SZ;
  localparam int ARB_LINE_W = CL_LEN * 8;

  // rw=1 is a read
  typedef struct packed {
    logic                  rw;
    logic [ARB_ADDR_W-1:0] rw_addr;
    logic [ARB_LINE_W-1:0] wr_data;
  } arb_data_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MREQ = 2'd1;
  localparam logic [1:0] MACK = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  // IC only ever reads, so its request carries no write line
  function automatic arb_data_t ic_to_req(
    input logic [ARB_ADDR_W-1:0] addr
  );
    arb_data_t r;
    r.rw      = 1'b1;
    r.rw_addr = addr;
    r.wr_data = '0;
    return r;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way combinational grant between IC and DC requesters.
// In: valid_ic, valid_dc, last_owner. Out: grant_ic, grant_dc.
// CACHE_ARB_DC_PRIORITY_EN: DC wins every tie, last_owner ignored.
module arb_rr2
  import cache_arbiter_pkg::*;
(
  input  logic valid_ic,
  input  logic valid_dc,
  input  logic last_owner,
  output logic grant_ic,
  output logic grant_dc
);

`ifdef CACHE_ARB_DC_PRIORITY_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign grant_dc = valid_dc;
  assign grant_ic = valid_ic && !valid_dc;
`else
  // on a tie the requester that did not go last wins
  assign grant_ic = valid_ic &&
                    (!valid_dc || last_owner == OWN_DC);
  assign grant_dc = valid_dc && !grant_ic;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Shares one system-memory line port between L1 IC and L1 DC.
// Ports: clk_in/reset_in, ic_req_*/ic_ack_*, dc_req_*/dc_ack_*, sm_req_*/sm_ack_*.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk_in,
  input  logic              reset_in,

  input  logic [ADDR_W-1:0] ic_req_addr,
  input  logic              ic_req_valid,
  output logic              ic_req_rdy,
  output logic [LINE_W-1:0] ic_ack_data,
  output logic              ic_ack_valid,
  input  logic              ic_ack_rdy,

  input  arb_data_t         dc_req_data,
  input  logic              dc_req_valid,
  output logic              dc_req_rdy,
  output logic [LINE_W-1:0] dc_ack_data,
  output logic              dc_ack_valid,
  input  logic              dc_ack_rdy,

  output logic              sm_req_rw,
  output logic [ADDR_W-1:0] sm_req_addr,
  output logic [LINE_W-1:0] sm_req_wr_data,
  output logic              sm_req_valid,
  input  logic              sm_req_rdy,
  input  logic [LINE_W-1:0] sm_ack_rd_data,
  input  logic              sm_ack_valid,
  output logic              sm_ack_rdy
);

  logic [1:0]        state;
  arb_data_t         req_reg;
  logic              owner;
  logic              last_owner;
  logic [LINE_W-1:0] line_reg;

  logic grant_ic;
  logic grant_dc;
  logic run;

  arb_rr2 u_rr (
    .valid_ic   (ic_req_valid),
    .valid_dc   (dc_req_valid),
    .last_owner (last_owner),
    .grant_ic   (grant_ic),
    .grant_dc   (grant_dc)
  );

  // every handshake output is held low while reset is asserted
  assign run = !reset_in;

  assign ic_req_rdy   = run && state == IDLE && grant_ic;
  assign dc_req_rdy   = run && state == IDLE && grant_dc;
  assign sm_req_valid = run && state == MREQ;
  assign sm_ack_rdy   = run && state == MACK;
  assign ic_ack_valid = run && state == RESP && owner == OWN_IC;
  assign dc_ack_valid = run && state == RESP && owner == OWN_DC;

  // driven straight from req_reg, so stable while MREQ stalls
  assign sm_req_rw      = req_reg.rw;
  assign sm_req_addr    = req_reg.rw_addr;
  assign sm_req_wr_data = req_reg.wr_data;

  assign ic_ack_data = line_reg;
  assign dc_ack_data = line_reg;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state      <= IDLE;
      req_reg    <= '0;
      owner      <= OWN_IC;
      last_owner <= OWN_DC;
      line_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          unique case (1'b1)
            grant_ic: begin
              req_reg    <= ic_to_req(ic_req_addr);
              owner      <= OWN_IC;
              last_owner <= OWN_IC;
              state      <= MREQ;
            end
            grant_dc: begin
              req_reg    <= dc_req_data;
              owner      <= OWN_DC;
              last_owner <= OWN_DC;
              state      <= MREQ;
            end
            default: ;
          endcase
        end
        MREQ: begin
          if (sm_req_rdy) state <= MACK;
        end
        MACK: begin
          if (sm_ack_valid) begin
            line_reg <= sm_ack_rd_data;
            state    <= RESP;
          end
        end
        RESP: begin
          if (owner == OWN_DC ? dc_ack_rdy : ic_ack_rdy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter.
// Vector table, corner sequences, random traffic vs. a memory model.
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

`ifdef CACHE_ARB_DC_PRIORITY_EN
  localparam bit DC_PRIO = 1'b1;
`else
  localparam bit DC_PRIO = 1'b0;
`endif

  logic         clk_in = 1'b0;
  logic         reset_in;
  logic [27:0]  ic_req_addr;
  logic         ic_req_valid;
  logic         ic_req_rdy;
  logic [127:0] ic_ack_data;
  logic         ic_ack_valid;
  logic         ic_ack_rdy;
  arb_data_t    dc_req_data;
  logic         dc_req_valid;
  logic         dc_req_rdy;
  logic [127:0] dc_ack_data;
  logic         dc_ack_valid;
  logic         dc_ack_rdy;
  logic         sm_req_rw;
  logic [27:0]  sm_req_addr;
  logic [127:0] sm_req_wr_data;
  logic         sm_req_valid;
  logic         sm_req_rdy;
  logic [127:0] sm_ack_rd_data;
  logic         sm_ack_valid;
  logic         sm_ack_rdy;

  always #5 clk_in = ~clk_in;

  cache_arbiter dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .ic_req_addr    (ic_req_addr),
    .ic_req_valid   (ic_req_valid),
    .ic_req_rdy     (ic_req_rdy),
    .ic_ack_data    (ic_ack_data),
    .ic_ack_valid   (ic_ack_valid),
    .ic_ack_rdy     (ic_ack_rdy),
    .dc_req_data    (dc_req_data),
    .dc_req_valid   (dc_req_valid),
    .dc_req_rdy     (dc_req_rdy),
    .dc_ack_data    (dc_ack_data),
    .dc_ack_valid   (dc_ack_valid),
    .dc_ack_rdy     (dc_ack_rdy),
    .sm_req_rw      (sm_req_rw),
    .sm_req_addr    (sm_req_addr),
    .sm_req_wr_data (sm_req_wr_data),
    .sm_req_valid   (sm_req_valid),
    .sm_req_rdy     (sm_req_rdy),
    .sm_ack_rd_data (sm_ack_rd_data),
    .sm_ack_valid   (sm_ack_valid),
    .sm_ack_rdy     (sm_ack_rdy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] hs_outs();
    return {ic_req_rdy, dc_req_rdy, ic_ack_valid,
            dc_ack_valid, sm_req_valid, sm_ack_rdy};
  endfunction

  task automatic clr_inputs();
    ic_req_addr    = '0;
    ic_req_valid   = 1'b0;
    ic_ack_rdy     = 1'b0;
    dc_req_data    = '0;
    dc_req_valid   = 1'b0;
    dc_ack_rdy     = 1'b0;
    sm_req_rdy     = 1'b0;
    sm_ack_rd_data = '0;
    sm_ack_valid   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    reset_in = 1'b1;
    clr_inputs();
    repeat (2) @(posedge clk_in);
    #1 reset_in = 1'b0;
  endtask

  typedef struct {
    bit           ic_v;
    bit           dc_v;
    bit           dc_rw;
    logic [27:0]  ic_addr;
    logic [27:0]  dc_addr;
    logic [127:0] wr;
    logic [127:0] line;
    bit           exp_dc;
  } vec_t;

  vec_t vt[5];

  // one transaction from IDLE with memory always ready
  task automatic apply_vec(input int idx, input vec_t v);
    bit           e_rw;
    logic [27:0]  e_addr;
    logic [127:0] e_wr;
    e_rw   = v.exp_dc ? v.dc_rw : 1'b1;
    e_addr = v.exp_dc ? v.dc_addr : v.ic_addr;
    e_wr   = v.exp_dc ? v.wr : 128'h0;
    @(posedge clk_in); #1;
    ic_req_valid        = v.ic_v;
    ic_req_addr         = v.ic_addr;
    dc_req_valid        = v.dc_v;
    dc_req_data.rw      = v.dc_rw;
    dc_req_data.rw_addr = v.dc_addr;
    dc_req_data.wr_data = v.wr;
    sm_req_rdy          = 1'b1;
    sm_ack_valid        = 1'b1;
    sm_ack_rd_data      = v.line;
    ic_ack_rdy          = 1'b1;
    dc_ack_rdy          = 1'b1;
    @(negedge clk_in);
    chk($sformatf("v%0d_ic_rdy", idx), ic_req_rdy, !v.exp_dc);
    chk($sformatf("v%0d_dc_rdy", idx), dc_req_rdy, v.exp_dc);
    @(posedge clk_in); #1;
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    @(negedge clk_in);
    chk($sformatf("v%0d_c1_valid", idx), sm_req_valid, 1'b1);
    chk($sformatf("v%0d_rw", idx), sm_req_rw, e_rw);
    chk($sformatf("v%0d_addr", idx), sm_req_addr, e_addr);
    chk($sformatf("v%0d_wr", idx), sm_req_wr_data, e_wr);
    @(negedge clk_in);
    chk($sformatf("v%0d_c2_ackrdy", idx),
        {sm_ack_rdy, ic_ack_valid, dc_ack_valid}, 3'b100);
    @(negedge clk_in);
    chk($sformatf("v%0d_c3_ackv", idx),
        {ic_ack_valid, dc_ack_valid}, {!v.exp_dc, v.exp_dc});
    chk($sformatf("v%0d_data", idx),
        v.exp_dc ? dc_ack_data : ic_ack_data, v.line);
  endtask

  // random-phase model state
  logic [127:0] mem [int];
  arb_data_t    cur;
  bit           cur_dc;
  bit           last_dc;
  bit           ic_busy;
  bit           dc_busy;
  bit           ack_pend;
  int           phase;
  logic [127:0] resp_line;
  logic [127:0] exp_line;
  int           txns;
  int           mem_reqs;

  localparam logic [127:0] LA5 = {16{8'hA5}};
  localparam logic [127:0] W12 = {8{16'h1234}};

  initial begin
    logic [127:0] junk;
    bit           exp_ic;
    bit           exp_dcg;

    reset_in = 1'b1;
    clr_inputs();

    vt[0] = '{1, 1, 1, 28'h0000200, 28'h0000300,
              128'h0, 128'h11, DC_PRIO};
    vt[1] = '{1, 1, 1, 28'h0000201, 28'h0000301,
              128'h0, 128'h22, 1'b1};
    vt[2] = '{1, 1, 1, 28'h0000202, 28'h0000302,
              128'h0, 128'h33, DC_PRIO};
    vt[3] = '{1, 0, 1, 28'h0000100, 28'h0,
              128'h0, LA5, 1'b0};
    vt[4] = '{0, 1, 0, 28'h0, 28'h0ABCDEF,
              W12, 128'h44, 1'b1};

    do_reset();
    @(negedge clk_in);
    chk("reset_hs", hs_outs(), 6'h0);
    chk("reset_req", {sm_req_rw, sm_req_addr, sm_req_wr_data}, 0);
    chk("reset_line", ic_ack_data, 128'h0);

    for (int i = 0; i < 5; i++) apply_vec(i, vt[i]);

    // DC write with memory stalling the request for 3 cycles
    junk = {4{32'hDEADBEEF}};
    @(posedge clk_in); #1;
    dc_req_valid = 1'b1;
    dc_req_data  = '{1'b0, 28'h0ABCDEF, W12};
    sm_req_rdy   = 1'b0;
    sm_ack_valid = 1'b0;
    @(negedge clk_in);
    chk("wr_dc_rdy", {ic_req_rdy, dc_req_rdy}, 2'b01);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_in); #1;
      dc_req_valid = 1'b0;
      sm_req_rdy   = (k == 3);
      @(negedge clk_in);
      chk($sformatf("wr_hold%0d", k),
          {sm_req_valid, sm_req_rw, sm_req_addr, sm_req_wr_data},
          {1'b1, 1'b0, 28'h0ABCDEF, W12});
    end
    @(posedge clk_in); #1;
    sm_req_rdy = 1'b0;
    @(negedge clk_in);
    chk("wr_mack_wait", {sm_ack_rdy, dc_ack_valid}, 2'b10);
    @(posedge clk_in); #1;
    sm_ack_valid   = 1'b1;
    sm_ack_rd_data = junk;
    @(negedge clk_in);
    chk("wr_mack", {sm_ack_rdy, dc_ack_valid}, 2'b10);
    @(posedge clk_in); #1;
    sm_ack_valid = 1'b0;
    @(negedge clk_in);
    chk("wr_ack", {ic_ack_valid, dc_ack_valid}, 2'b01);
    chk("wr_ack_data", dc_ack_data, junk);

    // DC ack back-pressure with a competing IC request
    @(posedge clk_in); #1;
    dc_req_valid   = 1'b1;
    dc_req_data    = '{1'b1, 28'h55, 128'h0};
    sm_req_rdy     = 1'b1;
    sm_ack_valid   = 1'b1;
    sm_ack_rd_data = 128'hC0FFEE;
    dc_ack_rdy     = 1'b0;
    @(negedge clk_in);
    chk("bp_dc_rdy", dc_req_rdy, 1'b1);
    @(posedge clk_in); #1;
    dc_req_valid = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 sm_ack_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ic_req_valid = 1'b1;
      ic_req_addr  = 28'h77;
      @(negedge clk_in);
      chk($sformatf("bp_hold%0d", k),
          {dc_ack_valid, ic_req_rdy, dc_req_rdy, dc_ack_data},
          {3'b100, 128'hC0FFEE});
      @(posedge clk_in); #1;
    end
    dc_ack_rdy = 1'b1;
    @(negedge clk_in);
    chk("bp_release", {dc_ack_valid, ic_req_rdy}, 2'b10);
    @(posedge clk_in); #1;
    sm_ack_rd_data = 128'hBEEF;
    @(negedge clk_in);
    chk("bp_ic_acc", ic_req_rdy, 1'b1);
    @(posedge clk_in); #1;
    ic_req_valid = 1'b0;
    sm_ack_valid = 1'b1;
    @(negedge clk_in);
    chk("bp_ic_mreq", {sm_req_valid, sm_req_rw, sm_req_addr},
        {2'b11, 28'h77});
    @(negedge clk_in);
    @(negedge clk_in);
    chk("bp_ic_ack", {ic_ack_valid, ic_ack_data}, {1'b1, 128'hBEEF});

    // reset while waiting for the memory acknowledge
    @(posedge clk_in); #1;
    ic_req_valid = 1'b1;
    ic_req_addr  = 28'h33;
    sm_ack_valid = 1'b0;
    @(negedge clk_in);
    chk("rst_acc", ic_req_rdy, 1'b1);
    @(posedge clk_in); #1;
    ic_req_valid = 1'b0;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk("rst_in_mack", sm_ack_rdy, 1'b1);
    @(posedge clk_in); #1;
    reset_in = 1'b1;
    @(negedge clk_in);
    chk("rst_gate", hs_outs(), 6'h0);
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    @(negedge clk_in);
    chk("rst_after", hs_outs(), 6'h0);
    apply_vec(9, '{1, 0, 1, 28'h44, 28'h0, 128'h0,
                   128'h5A5A, 1'b0});

    // random traffic against a memory model
    do_reset();
    last_dc  = 1'b1;
    ic_busy  = 0;
    dc_busy  = 0;
    ack_pend = 0;
    phase    = 0;
    txns     = 0;
    mem_reqs = 0;
    for (int cyc = 0; cyc < 60000 && txns < 1000; cyc++) begin
      @(negedge clk_in);
      if (phase == 0) begin
        exp_ic  = ic_req_valid &&
                  (!dc_req_valid || (!DC_PRIO && last_dc));
        exp_dcg = dc_req_valid && !exp_ic;
        chk("rnd_grant", {ic_req_rdy, dc_req_rdy}, {exp_ic, exp_dcg});
      end else begin
        chk("rnd_busy_rdy", {ic_req_rdy, dc_req_rdy}, 2'b00);
      end
      chk("rnd_stray_ack",
          (ic_ack_valid || dc_ack_valid) && phase != 3, 1'b0);
      if (ic_req_valid && ic_req_rdy) begin
        cur     = '{1'b1, ic_req_addr, 128'h0};
        cur_dc  = 1'b0;
        last_dc = 1'b0;
        ic_busy = 1;
        phase   = 1;
      end else if (dc_req_valid && dc_req_rdy) begin
        cur     = dc_req_data;
        cur_dc  = 1'b1;
        last_dc = 1'b1;
        dc_busy = 1;
        phase   = 1;
      end
      if (sm_req_valid && sm_req_rdy) begin
        chk("rnd_mreq_phase", phase, 1);
        chk("rnd_mreq", {sm_req_rw, sm_req_addr, sm_req_wr_data}, cur);
        if (!cur.rw) begin
          mem[int'(cur.rw_addr)] = cur.wr_data;
          resp_line = {$urandom, $urandom, $urandom, $urandom};
        end else if (mem.exists(int'(cur.rw_addr))) begin
          resp_line = mem[int'(cur.rw_addr)];
        end else begin
          resp_line = '0;
        end
        ack_pend = 1;
        phase    = 2;
        mem_reqs++;
      end
      if (sm_ack_valid && sm_ack_rdy) begin
        chk("rnd_mack_phase", phase, 2);
        exp_line = resp_line;
        ack_pend = 0;
        phase    = 3;
      end
      if (ic_ack_valid && ic_ack_rdy) begin
        chk("rnd_ic_ack", {phase == 3, cur_dc, ic_ack_data},
            {2'b10, exp_line});
        ic_busy = 0;
        phase   = 0;
        txns++;
      end
      if (dc_ack_valid && dc_ack_rdy) begin
        chk("rnd_dc_ack", {phase == 3, cur_dc, dc_ack_data},
            {2'b11, exp_line});
        dc_busy = 0;
        phase   = 0;
        txns++;
      end
      @(posedge clk_in); #1;
      if (ic_busy) ic_req_valid = 1'b0;
      else if (!ic_req_valid && $urandom_range(0, 1) == 1) begin
        ic_req_valid = 1'b1;
        ic_req_addr  = 28'($urandom_range(0, 15));
      end
      if (dc_busy) dc_req_valid = 1'b0;
      else if (!dc_req_valid && $urandom_range(0, 1) == 1) begin
        dc_req_valid        = 1'b1;
        dc_req_data.rw      = 1'($urandom_range(0, 1));
        dc_req_data.rw_addr = 28'($urandom_range(0, 15));
        dc_req_data.wr_data = {$urandom, $urandom, $urandom, $urandom};
      end
      sm_req_rdy     = $urandom_range(0, 2) != 0;
      sm_ack_valid   = ack_pend && $urandom_range(0, 2) != 0;
      sm_ack_rd_data = ack_pend ? resp_line :
                       {$urandom, $urandom, $urandom, $urandom};
      ic_ack_rdy     = $urandom_range(0, 3) != 0;
      dc_ack_rdy     = $urandom_range(0, 3) != 0;
    end
    chk("rnd_txns", txns, 1000);
    chk("rnd_mem_reqs", mem_reqs, txns);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
